// File: rtl/fi_pattern_gen.sv
// Fault-injection control stream generator: sweeps signal x mask x cycle and emits one record per combination.
// Optional macro FI_PATGEN_DOUBLE_BIT_EN appends adjacent double-bit masks after the single-bit ones.
module fi_pattern_gen #(
  parameter int NUM_SIGNALS = 1,
  parameter int BIT_W       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] case_len,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [63:0] rec_sel,
  output logic [63:0] rec_mask,
  output logic [15:0] rec_cycle,
  output logic        rec_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] rec_count
);

`ifdef FI_PATGEN_DOUBLE_BIT_EN
  localparam int NUM_MASKS = 2 * BIT_W - 1;
`else
  localparam int NUM_MASKS = BIT_W;
`endif
  localparam int SEL_W = $clog2(NUM_SIGNALS) + 1;
  localparam int MI_W  = $clog2(NUM_MASKS) + 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SIGNALS - 1);
  localparam logic [MI_W-1:0]  MI_LAST  = MI_W'(NUM_MASKS - 1);
`ifdef FI_PATGEN_DOUBLE_BIT_EN
  localparam logic [MI_W-1:0]  MI_SINGLE = MI_W'(BIT_W);
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state, state_next;
  logic [SEL_W-1:0]  sel_cnt;
  logic [MI_W-1:0]   mask_idx;
  logic [15:0]       cyc_cnt;
  logic [15:0]       len_reg;
  logic              start_acc;
  logic              xfer;
  logic              cyc_wrap;
  logic              mask_wrap;
  logic              at_last;
  logic [63:0]       mask_val;

  assign start_acc = start && (state != RUN);
  assign xfer      = (state == RUN) && rec_ready;
  assign cyc_wrap  = (cyc_cnt == len_reg);
  assign mask_wrap = (mask_idx == MI_LAST);
  assign at_last   = (sel_cnt == SEL_LAST) && mask_wrap && cyc_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A start seen in FIN wins over the return to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (case_len != 16'd0) ? RUN : FIN;
      RUN:  if (xfer && at_last) state_next = FIN;
      FIN:  if (start) state_next = (case_len != 16'd0) ? RUN : FIN;
            else       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sweep position: cycle innermost, then mask index, then signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_cnt  <= '0;
      mask_idx <= '0;
      cyc_cnt  <= '0;
      len_reg  <= '0;
    end else if (start_acc) begin
      sel_cnt  <= '0;
      mask_idx <= '0;
      cyc_cnt  <= 16'd1;
      len_reg  <= case_len;
    end else if (xfer && !at_last) begin
      if (cyc_wrap) begin
        cyc_cnt <= 16'd1;
        if (mask_wrap) begin
          mask_idx <= '0;
          sel_cnt  <= sel_cnt + 1'b1;
        end else begin
          mask_idx <= mask_idx + 1'b1;
        end
      end else begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    rec_count <= '0;
    else if (start_acc)                         rec_count <= '0;
    else if (xfer && rec_count != 32'hFFFF_FFFF) rec_count <= rec_count + 32'd1;
  end

  always_comb begin
    mask_val = '0;
`ifdef FI_PATGEN_DOUBLE_BIT_EN
    if (mask_idx < MI_SINGLE) mask_val = 64'd1 << mask_idx;
    else                      mask_val = 64'd3 << (mask_idx - MI_SINGLE);
`else
    mask_val = 64'd1 << mask_idx;
`endif
  end

  // Record fields read as zero whenever no record is on offer.
  assign rec_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == FIN);
  assign rec_sel   = rec_valid ? 64'(sel_cnt) : 64'd0;
  assign rec_mask  = rec_valid ? mask_val : 64'd0;
  assign rec_cycle = rec_valid ? cyc_cnt : 16'd0;
  assign rec_last  = rec_valid && at_last;

endmodule

// File: tb/tb_fi_pattern_gen.sv
// Self-checking bench for fi_pattern_gen (NUM_SIGNALS=2, BIT_W=4) against a queue-based record model.
// Honours FI_PATGEN_DOUBLE_BIT_EN when building the expected mask list.
module tb_fi_pattern_gen;

  localparam int NS = 2;
  localparam int BW = 4;
`ifdef FI_PATGEN_DOUBLE_BIT_EN
  localparam int NM = 2 * BW - 1;
`else
  localparam int NM = BW;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] case_len = '0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [63:0] rec_sel;
  logic [63:0] rec_mask;
  logic [15:0] rec_cycle;
  logic        rec_last;
  logic        busy;
  logic        done;
  logic [31:0] rec_count;

  fi_pattern_gen #(.NUM_SIGNALS(NS), .BIT_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .case_len(case_len),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_sel(rec_sel),
    .rec_mask(rec_mask), .rec_cycle(rec_cycle), .rec_last(rec_last),
    .busy(busy), .done(done), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sel;
    logic [63:0] mask;
    logic [15:0] cyc;
  } rec_t;

  rec_t q[$];
  int   m_idx   = 0;
  bit   m_valid = 0;
  bit   m_done  = 0;
  int   m_count = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Full campaign as an ordered list: signal, then mask list entry, then cycle.
  function automatic void buildQueue(input int len);
    rec_t r;
    q.delete();
    for (int s = 0; s < NS; s++)
      for (int mi = 0; mi < NM; mi++)
        for (int c = 1; c <= len; c++) begin
          r.sel  = 64'(s);
          r.mask = (mi < BW) ? (64'd1 << mi) : (64'd3 << (mi - BW));
          r.cyc  = 16'(c);
          q.push_back(r);
        end
  endfunction

  // Model: idle / running through q / one done cycle.
  always @(posedge clk or posedge rst) begin
    bit prev_valid;
    if (rst) begin
      m_valid = 0; m_done = 0; m_count = 0; m_idx = 0;
    end else begin
      prev_valid = m_valid;
      m_done = 0;
      if (prev_valid && rec_ready) begin
        m_count++;
        m_idx++;
        if (m_idx == q.size()) begin
          m_valid = 0;
          m_done  = 1;
        end
      end
      if (!prev_valid && start) begin
        buildQueue(int'(case_len));
        m_idx = 0;
        m_count = 0;
        if (case_len == 16'd0) m_done = 1;
        else                   m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rec_valid", rec_valid, m_valid);
      checkOutput("busy", busy, m_valid);
      checkOutput("done", done, m_done);
      checkOutput("rec_count", rec_count, m_count);
      if (m_valid && m_idx < q.size()) begin
        checkOutput("rec_sel", rec_sel, q[m_idx].sel);
        checkOutput("rec_mask", rec_mask, q[m_idx].mask);
        checkOutput("rec_cycle", rec_cycle, q[m_idx].cyc);
        checkOutput("rec_last", rec_last, m_idx == q.size() - 1);
      end
    end
  end

  task automatic waitDone(input int ready_mode, input bit start_noise);
    bit finished = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_done) begin
        finished = 1;
        break;
      end
      case (ready_mode)
        0:       rec_ready = 1'b1;
        1:       rec_ready = ~rec_ready;
        default: rec_ready = 1'($urandom_range(0, 1));
      endcase
      if (start_noise) start = m_valid && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    if (!finished) checkOutput("campaign_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input int len, input int ready_mode, input bit start_noise);
    @(negedge clk);
    start = 1'b1;
    case_len = 16'(len);
    rec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    case_len = 16'($urandom);
    waitDone(ready_mode, start_noise);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1;
    checkOutput("reset_valid", rec_valid, 0);
    checkOutput("reset_sel", rec_sel, 0);
    checkOutput("reset_mask", rec_mask, 0);
    checkOutput("reset_cycle", rec_cycle, 0);
    checkOutput("reset_last", rec_last, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_count", rec_count, 0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3, 0, 1'b0);
`ifdef FI_PATGEN_DOUBLE_BIT_EN
    checkOutput("pin_size", q.size(), 42);
    checkOutput("pin_r12_mask", q[12].mask, 64'h3);
    checkOutput("pin_r12_cyc", q[12].cyc, 1);
    checkOutput("pin_rlast_sel", q[41].sel, 1);
    checkOutput("pin_rlast_mask", q[41].mask, 64'hC);
    checkOutput("pin_rlast_cyc", q[41].cyc, 3);
    checkOutput("pin_count", rec_count, 42);
`else
    checkOutput("pin_size", q.size(), 24);
    checkOutput("pin_r0_mask", q[0].mask, 64'h1);
    checkOutput("pin_r3_mask", q[3].mask, 64'h2);
    checkOutput("pin_r3_cyc", q[3].cyc, 1);
    checkOutput("pin_r23_sel", q[23].sel, 1);
    checkOutput("pin_r23_mask", q[23].mask, 64'h8);
    checkOutput("pin_r23_cyc", q[23].cyc, 3);
    checkOutput("pin_count", rec_count, 24);
`endif

    applyStimulus(3, 1, 1'b0);
    checkOutput("toggle_count", rec_count, NS * NM * 3);

    applyStimulus(0, 0, 1'b0);
    checkOutput("zero_len_count", rec_count, 0);

    for (int k = 0; k < 4; k++) applyStimulus($urandom_range(1, 4), 2, 1'b1);

    // Start held through RUN and into FIN restarts immediately.
    @(negedge clk);
    start = 1'b1;
    case_len = 16'd1;
    rec_ready = 1'b1;
    @(negedge clk);
    waitDone(0, 1'b0);
    @(negedge clk);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_count", rec_count, 0);
    start = 1'b0;
    waitDone(2, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of a campaign.
    start = 1'b1;
    case_len = 16'd3;
    rec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && m_idx != 10; i++) @(negedge clk);
    checkOutput("pre_reset_index", m_idx, 10);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", rec_valid, 0);
    checkOutput("midrst_sel", rec_sel, 0);
    checkOutput("midrst_mask", rec_mask, 0);
    checkOutput("midrst_cycle", rec_cycle, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_count", rec_count, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    case_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    checkOutput("fresh_valid", rec_valid, 1);
    checkOutput("fresh_sel", rec_sel, 0);
    checkOutput("fresh_mask", rec_mask, 64'h1);
    checkOutput("fresh_cycle", rec_cycle, 1);
    waitDone(2, 1'b0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
